// File: rtl/seq_multiplier_if.sv
// Handshake bundle between a multiply requester and the sequential multiplier.
// The requester drives the master side and the multiplier sits on the slave side.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       mul_type;
  logic [WIDTH-1:0] a_multiply;
  logic [WIDTH-1:0] b_multiply;
  logic [WIDTH-1:0] answer;
  logic             mul_done;
  logic             multiplier_ready;

  modport master (
    output start, mul_type, a_multiply, b_multiply,
    input  answer, mul_done, multiplier_ready
  );

  modport slave (
    input  start, mul_type, a_multiply, b_multiply,
    output answer, mul_done, multiplier_ready
  );

endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier with RISC-V M-extension result selection.
// Multiplies sign-stripped magnitudes, then fixes the sign before picking a half.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  seq_multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [1:0] MulLo  = 2'b00;
  localparam logic [1:0] MulH   = 2'b01;
  localparam logic [1:0] MulHsu = 2'b10;

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           type_q, type_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     answer_q, answer_d;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   res;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    answer_d = answer_q;

    // Only the operands that the selected type treats as signed contribute a sign.
    sign_a = bus.a_multiply[WIDTH-1] & ((bus.mul_type == MulH) || (bus.mul_type == MulHsu));
    sign_b = bus.b_multiply[WIDTH-1] & (bus.mul_type == MulH);
    abs_a  = sign_a ? -bus.a_multiply : bus.a_multiply;
    abs_b  = sign_b ? -bus.b_multiply : bus.b_multiply;

    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    res = neg_q ? -prod_q : prod_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          type_d   = bus.mul_type;
          neg_d    = sign_a ^ sign_b;
          mcand_d  = abs_a;
          mplier_d = abs_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // The add carry becomes the new MSB as the product shifts right.
        prod_d   = {sum, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        answer_d = (type_q == MulLo) ? res[WIDTH-1:0] : res[2*WIDTH-1:WIDTH];
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      type_q   <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      answer_q <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      answer_q <= answer_d;
    end
  end

  assign bus.answer           = answer_q;
  assign bus.mul_done         = (state_q == StDone);
  assign bus.multiplier_ready = (state_q == StIdle);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: result selection, latency, ignored starts,
// mid-operation reset and back-to-back requests.
module tb_seq_multiplier;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it until the multiplier is ready again.
  // lat counts edges from acceptance to the first sample showing mul_done.
  task automatic run_op(input logic [1:0] mt, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit scramble,
                        output int lat, output int nr, output int pulses,
                        output logic [31:0] ans);
    int edges;
    @(negedge clk);
    bus.mul_type   = mt;
    bus.a_multiply = a;
    bus.b_multiply = b;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    lat    = -1;
    nr     = 0;
    pulses = 0;
    ans    = 32'hDEAD_BEEF;
    edges  = 0;
    while (edges < 100) begin
      if (bus.mul_done) begin
        pulses++;
        if (lat < 0) begin
          lat = edges;
          ans = bus.answer;
        end
      end
      if (bus.multiplier_ready) break;
      nr++;
      if (scramble) begin
        bus.mul_type   = 2'($urandom);
        bus.a_multiply = $urandom;
        bus.b_multiply = $urandom;
      end
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  logic [1:0]  vt [6];
  logic [31:0] va [6];
  logic [31:0] vb [6];
  logic [31:0] ve [6];

  initial begin
    int lat, nr, pulses, cnt;
    logic [31:0] ans;
    checks = 0;
    errors = 0;

    vt[0] = 2'b01; va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 32'h0000_0000;
    vt[1] = 2'b11; va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; ve[1] = 32'hFFFF_FFFE;
    vt[2] = 2'b00; va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; ve[2] = 32'h0000_0001;
    vt[3] = 2'b10; va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0002; ve[3] = 32'hFFFF_FFFF;
    vt[4] = 2'b01; va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000; ve[4] = 32'h4000_0000;
    vt[5] = 2'b01; va[5] = 32'h8000_0000; vb[5] = 32'h0000_0001; ve[5] = 32'hFFFF_FFFF;

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.mul_type   = 2'b00;
    bus.a_multiply = '0;
    bus.b_multiply = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_answer", bus.answer, 32'h0);
    check("reset_done", 32'(bus.mul_done), 32'h0);
    check("reset_ready", 32'(bus.multiplier_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 1'b0, 1'b0, lat, nr, pulses, ans);
    check("mul7x6_answer", ans, 32'h0000_002A);
    check("mul7x6_latency", 32'(lat), 32'd33);
    check("mul7x6_notready", 32'(nr), 32'd34);
    check("mul7x6_pulses", 32'(pulses), 32'd1);
    check("mul7x6_hold", bus.answer, 32'h0000_002A);

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i], va[i], vb[i], 1'b0, 1'b0, lat, nr, pulses, ans);
      check($sformatf("vec%0d_answer", i), ans, ve[i]);
      check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'd1);
    end

    // Start stays high and operands churn while busy; only the first request counts.
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, lat, nr, pulses, ans);
    bus.start = 1'b0;
    check("busy_ignore_answer", ans, 32'hFFFF_FFFE);
    check("busy_ignore_latency", 32'(lat), 32'd33);
    check("busy_ignore_pulses", 32'(pulses), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_ignore_idle_ready", 32'(bus.multiplier_ready), 32'h1);
    check("busy_ignore_idle_done", 32'(bus.mul_done), 32'h0);
    check("busy_ignore_stable", bus.answer, 32'hFFFF_FFFE);

    // Reset during iteration 10 of a MUL 3x5.
    @(negedge clk);
    bus.mul_type   = 2'b00;
    bus.a_multiply = 32'd3;
    bus.b_multiply = 32'd5;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_answer", bus.answer, 32'h0);
    check("midreset_done", 32'(bus.mul_done), 32'h0);
    check("midreset_ready", 32'(bus.multiplier_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.mul_done) cnt++;
    end
    check("midreset_no_pulse", 32'(cnt), 32'd0);
    check("midreset_answer_kept", bus.answer, 32'h0);

    run_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, lat, nr, pulses, ans);
    check("mul3x5_answer", ans, 32'h0000_000F);
    check("mul3x5_latency", 32'(lat), 32'd33);

    // Back-to-back with start held: second request lands one idle cycle later.
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, nr, pulses, ans);
    check("b2b_first_answer", ans, 32'hFFFF_FFFE);
    check("b2b_first_notready", 32'(nr), 32'd34);
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, lat, nr, pulses, ans);
    bus.start = 1'b0;
    check("b2b_second_answer", ans, 32'h0000_0000);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_notready", 32'(nr), 32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
